// File: rtl/uart_test_pkg.sv
// Shared UART test-link definitions: FSM state encoding, frame width, mid-bit helper.
// Macro UART_TEST_RX_PARITY_EN (in consumers) enables the PARITY state usage.
package uart_test_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } uart_state_t;

  // Count value at which the start bit is re-checked, i.e. its middle.
  function automatic logic [7:0] half_bit(input int clks);
    return 8'((clks - 1) / 2);
  endfunction

endpackage

// File: rtl/uart_test_sync2.sv
// Two-flop synchroniser for an asynchronous level; 2 cycles latency, no backpressure.
// Reset value is a parameter so an idle-high line does not look like a start bit.
module uart_test_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_test_rx.sv
// 8N1 UART receiver, mid-bit sampling, DV / framing-error strobes; no backpressure (byte held until next DV).
// Latency: start edge to DV = 2 + HALF+1 + 9*CLKS_PER_BIT + 1; UART_TEST_RX_PARITY_EN adds an even-parity bit.
module uart_test_rx
  import uart_test_pkg::*;
#(
  parameter int CLKS_PER_BIT = 0
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
`ifdef UART_TEST_RX_PARITY_EN
  ,
  output logic       o_Rx_Parity_Err
`endif
);

  localparam logic [7:0] HALF = half_bit(CLKS_PER_BIT);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_test_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .d       (i_Rx_Serial),
    .q       (rx_s)
  );

  uart_state_t    state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [7:0]     byte_q, byte_d;
  logic           dv_q, dv_d;
  logic           fe_q, fe_d;
  logic           act_q, act_d;
`ifdef UART_TEST_RX_PARITY_EN
  logic           par_q, par_d;
  logic           pe_q, pe_d;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      act_q   <= 1'b0;
`ifdef UART_TEST_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      act_q   <= act_d;
`ifdef UART_TEST_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    byte_d  = byte_q;
    act_d   = act_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_TEST_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        act_d = 1'b0;
        if (!rx_s) begin
          state_d = START;
          act_d   = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            // Start bit gone by mid-bit: treat as a line glitch.
            state_d = IDLE;
            act_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TEST_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef UART_TEST_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          act_d   = 1'b0;
          state_d = CLEANUP;
          // A bad stop bit suppresses both the byte and any parity report.
          if (rx_s) begin
            byte_d = data_q;
            dv_d   = 1'b1;
`ifdef UART_TEST_RX_PARITY_EN
            pe_d   = ^data_q ^ par_q;
`endif
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CLEANUP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        act_d   = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Active    = act_q;
  assign o_Rx_Frame_Err = fe_q;
`ifdef UART_TEST_RX_PARITY_EN
  assign o_Rx_Parity_Err = pe_q;
`endif

endmodule
